// File: rtl/reset_seq_if.sv
// Request/mask inputs and staged reset outputs of the reset sequencer.
// The slave side belongs to reset_seq; the master side belongs to whatever drives the requests.
interface reset_seq_if #(
  parameter int NUM_SRC = 2,
  parameter int NUM_OUT = 3
);
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] req_mask;
  logic               cause_clr;
  logic [NUM_OUT-1:0] res;
  logic               busy;
  logic [NUM_SRC-1:0] cause;
  logic               por;

  modport master (
    output req, req_mask, cause_clr,
    input  res, busy, cause, por
  );

  modport slave (
    input  req, req_mask, cause_clr,
    output res, busy, cause, por
  );
endinterface

// File: rtl/reset_seq.sv
// Multi-source reset sequencer: synchronises and debounces maskable requests, holds all domains,
// then releases them one at a time while recording which request bits caused the reset.
module reset_seq #(
  parameter int NUM_SRC         = 2,
  parameter int NUM_OUT         = 3,
  parameter int DELAY_CYCLES    = 99,
  parameter int STAGE_CYCLES    = 4,
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int CNT_W           = 32
) (
  input  logic        clock,
  input  logic        async_res_n,
  reset_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] DELAY_C      = CNT_W'(DELAY_CYCLES);
  localparam logic [CNT_W-1:0] STAGE_RELOAD = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_MAX      = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  logic [NUM_SRC-1:0] sync1_r;
  logic [NUM_SRC-1:0] sync2_r;
  logic [CNT_W-1:0]   deb_cnt_r;
  logic [CNT_W-1:0]   deb_cnt_s;
  logic [NUM_SRC-1:0] req_eff_s;
  logic               act_raw_s;
  logic               act_s;

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   hold_cnt_r;
  logic [CNT_W-1:0]   hold_cnt_s;
  logic [CNT_W-1:0]   stage_cnt_r;
  logic [CNT_W-1:0]   stage_cnt_s;
  logic [NUM_OUT-1:0] res_r;
  logic [NUM_OUT-1:0] res_s;
  logic               busy_r;
  logic               busy_s;
  logic [NUM_SRC-1:0] cause_r;
  logic [NUM_SRC-1:0] cause_s;
  logic [NUM_SRC-1:0] cause_base_s;
  logic               por_r;
  logic               por_s;

  // Request qualification: a request is only valid once it has stayed high past the debounce window.
  always_comb begin
    req_eff_s = sync2_r & ~bus.req_mask;
    act_raw_s = |req_eff_s;
    deb_cnt_s = deb_cnt_r;
    if (!act_raw_s) begin
      deb_cnt_s = '0;
    end else if (deb_cnt_r != DEB_MAX) begin
      deb_cnt_s = deb_cnt_r + ONE_C;
    end else begin
      deb_cnt_s = deb_cnt_r;
    end
    act_s = act_raw_s && (deb_cnt_r == DEB_MAX);
  end

  // Two-flop synchroniser and debounce counter.
  always_ff @(posedge clock or negedge async_res_n) begin
    if (!async_res_n) begin
      sync1_r   <= '0;
      sync2_r   <= '0;
      deb_cnt_r <= '0;
    end else begin
      sync1_r   <= bus.req;
      sync2_r   <= sync1_r;
      deb_cnt_r <= deb_cnt_s;
    end
  end

  // Sequencer next state: shifting res left clears the lowest still-asserted domain each stage.
  always_comb begin
    state_s     = state_r;
    hold_cnt_s  = hold_cnt_r;
    stage_cnt_s = stage_cnt_r;
    res_s       = res_r;
    case (state_r)
      HOLD: begin
        if (act_s) begin
          hold_cnt_s = DELAY_C;
        end else if (hold_cnt_r != '0) begin
          hold_cnt_s = hold_cnt_r - ONE_C;
        end else begin
          res_s       = res_r << 1'b1;
          stage_cnt_s = STAGE_RELOAD;
          if (NUM_OUT == 1) begin
            state_s = RUN;
          end else begin
            state_s = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (act_s) begin
          state_s    = HOLD;
          res_s      = '1;
          hold_cnt_s = DELAY_C;
        end else if (stage_cnt_r != '0) begin
          stage_cnt_s = stage_cnt_r - ONE_C;
        end else begin
          res_s       = res_r << 1'b1;
          stage_cnt_s = STAGE_RELOAD;
          if ((res_r << 1'b1) == '0) begin
            state_s = RUN;
          end else begin
            state_s = RELEASE;
          end
        end
      end
      RUN: begin
        if (act_s) begin
          state_s    = HOLD;
          res_s      = '1;
          hold_cnt_s = DELAY_C;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s    = HOLD;
        res_s      = '1;
        hold_cnt_s = DELAY_C;
      end
    endcase
    busy_s = |res_s;
  end

  // Cause bookkeeping: a clear and a simultaneous new cause resolve in favour of the new cause.
  always_comb begin
    if (bus.cause_clr) begin
      cause_base_s = '0;
      por_s        = 1'b0;
    end else begin
      cause_base_s = cause_r;
      por_s        = por_r;
    end
    if (act_s) begin
      cause_s = cause_base_s | req_eff_s;
    end else begin
      cause_s = cause_base_s;
    end
  end

  // Sequencer and status registers.
  always_ff @(posedge clock or negedge async_res_n) begin
    if (!async_res_n) begin
      state_r     <= HOLD;
      hold_cnt_r  <= DELAY_C;
      stage_cnt_r <= '0;
      res_r       <= '1;
      busy_r      <= 1'b1;
      cause_r     <= '0;
      por_r       <= 1'b1;
    end else begin
      state_r     <= state_s;
      hold_cnt_r  <= hold_cnt_s;
      stage_cnt_r <= stage_cnt_s;
      res_r       <= res_s;
      busy_r      <= busy_s;
      cause_r     <= cause_s;
      por_r       <= por_s;
    end
  end

  assign bus.res   = res_r;
  assign bus.busy  = busy_r;
  assign bus.cause = cause_r;
  assign bus.por   = por_r;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: fixed vector table, multi-cycle scenario sequences and a random phase,
// all compared against an edge-count timeline model of the sequencer.
module tb_reset_seq;
  localparam int NS  = 2;
  localparam int NO  = 3;
  localparam int DLY = 4;
  localparam int STG = 2;
  localparam int DEB = 2;

  logic clock = 1'b0;
  logic async_res_n;

  reset_seq_if #(.NUM_SRC(NS), .NUM_OUT(NO)) bus ();

  reset_seq #(
    .NUM_SRC(NS), .NUM_OUT(NO), .DELAY_CYCLES(DLY),
    .STAGE_CYCLES(STG), .DEBOUNCE_CYCLES(DEB), .CNT_W(8)
  ) dut (
    .clock(clock),
    .async_res_n(async_res_n),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Model: outputs follow from how many edges have passed since the last trigger (or reset release).
  logic [NS-1:0] m_s1, m_s2;
  logic [NS-1:0] m_cause;
  logic          m_por;
  int            m_run, m_n, m_last;

  typedef struct {
    logic [NS-1:0] req;
    logic [NS-1:0] mask;
    logic          clr;
    int            cycles;
    logic [NO-1:0] res;
    logic          busy;
    logic [NS-1:0] cause;
    logic          por;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] dut_out();
    return {bus.res, bus.busy, bus.cause, bus.por};
  endfunction

  function automatic logic [6:0] m_out();
    logic [NO-1:0] r;
    for (int k = 0; k < NO; k++) r[k] = ((m_n - m_last) < (DLY + 1 + k * STG));
    return {r, |r, m_cause, m_por};
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_run = 0; m_n = 0; m_last = 0;
    m_cause = '0; m_por = 1'b1;
  endtask

  task automatic model_edge();
    logic [NS-1:0] eff;
    logic act;
    eff = m_s2 & ~bus.req_mask;
    act = (|eff) && (m_run >= DEB);
    if (|eff) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_run = 0;
    end
    m_cause = (bus.cause_clr ? '0 : m_cause) | (act ? eff : '0);
    m_por   = bus.cause_clr ? 1'b0 : m_por;
    m_n++;
    if (act) m_last = m_n;
    m_s2 = m_s1;
    m_s1 = bus.req;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    check("cycle", 32'(dut_out()), 32'(m_out()));
  endtask

  task automatic run(input logic [NS-1:0] r, input logic [NS-1:0] m, input logic c, input int n);
    bus.req = r; bus.req_mask = m; bus.cause_clr = c;
    repeat (n) tick();
  endtask

  task automatic expect_out(input string name, input logic [NO-1:0] r, input logic b,
                            input logic [NS-1:0] c, input logic p);
    check(name, 32'(dut_out()), 32'({r, b, c, p}));
  endtask

  task automatic apply_async();
    async_res_n = 1'b0;
    #1;
    model_reset();
    expect_out("async_immediate", 3'b111, 1'b1, 2'b00, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    async_res_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{2'b00, 2'b00, 1'b0, 4, 3'b111, 1'b1, 2'b00, 1'b1};
    tbl[1]  = '{2'b00, 2'b00, 1'b0, 1, 3'b110, 1'b1, 2'b00, 1'b1};
    tbl[2]  = '{2'b00, 2'b00, 1'b0, 2, 3'b100, 1'b1, 2'b00, 1'b1};
    tbl[3]  = '{2'b00, 2'b00, 1'b0, 2, 3'b000, 1'b0, 2'b00, 1'b1};
    tbl[4]  = '{2'b01, 2'b00, 1'b0, 2, 3'b000, 1'b0, 2'b00, 1'b1};
    tbl[5]  = '{2'b00, 2'b00, 1'b0, 4, 3'b000, 1'b0, 2'b00, 1'b1};
    tbl[6]  = '{2'b01, 2'b00, 1'b0, 3, 3'b000, 1'b0, 2'b00, 1'b1};
    tbl[7]  = '{2'b00, 2'b00, 1'b0, 1, 3'b000, 1'b0, 2'b00, 1'b1};
    tbl[8]  = '{2'b00, 2'b00, 1'b0, 1, 3'b111, 1'b1, 2'b01, 1'b1};
    tbl[9]  = '{2'b00, 2'b00, 1'b0, 4, 3'b111, 1'b1, 2'b01, 1'b1};
    tbl[10] = '{2'b00, 2'b00, 1'b0, 5, 3'b000, 1'b0, 2'b01, 1'b1};

    async_res_n   = 1'b0;
    bus.req       = '0;
    bus.req_mask  = '0;
    bus.cause_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    expect_out("power_on_state", 3'b111, 1'b1, 2'b00, 1'b1);
    async_res_n = 1'b1;

    // Power-on release timing and the debounce glitch filter.
    for (int i = 0; i < 11; i++) begin
      run(tbl[i].req, tbl[i].mask, tbl[i].clr, tbl[i].cycles);
      expect_out($sformatf("table_row%0d", i), tbl[i].res, tbl[i].busy, tbl[i].cause, tbl[i].por);
    end

    // Held request: release counts from the last valid cycle.
    run(2'b00, 2'b00, 1'b1, 1);
    run(2'b10, 2'b00, 1'b0, 10);
    run(2'b00, 2'b00, 1'b0, 6);
    expect_out("held_still_asserted", 3'b111, 1'b1, 2'b10, 1'b0);
    run(2'b00, 2'b00, 1'b0, 1);
    expect_out("held_res0_release", 3'b110, 1'b1, 2'b10, 1'b0);
    run(2'b00, 2'b00, 1'b0, 4);
    expect_out("held_all_released", 3'b000, 1'b0, 2'b10, 1'b0);

    // Masked source ignored, unmasked source still triggers.
    run(2'b00, 2'b00, 1'b1, 1);
    run(2'b01, 2'b01, 1'b0, 10);
    run(2'b00, 2'b01, 1'b0, 4);
    expect_out("mask_ignored", 3'b000, 1'b0, 2'b00, 1'b0);
    run(2'b10, 2'b01, 1'b0, 10);
    expect_out("mask_other_src", 3'b111, 1'b1, 2'b10, 1'b0);
    run(2'b00, 2'b00, 1'b0, 12);
    expect_out("mask_released", 3'b000, 1'b0, 2'b10, 1'b0);

    // Re-trigger between res[0] and res[1] release.
    run(2'b01, 2'b00, 1'b0, 3);
    run(2'b00, 2'b00, 1'b0, 2);
    expect_out("retrig_first", 3'b111, 1'b1, 2'b11, 1'b0);
    run(2'b00, 2'b00, 1'b0, 1);
    run(2'b01, 2'b00, 1'b0, 3);
    run(2'b00, 2'b00, 1'b0, 1);
    expect_out("retrig_res0_low", 3'b110, 1'b1, 2'b11, 1'b0);
    run(2'b00, 2'b00, 1'b0, 1);
    expect_out("retrig_reassert", 3'b111, 1'b1, 2'b11, 1'b0);
    run(2'b00, 2'b00, 1'b0, 4);
    expect_out("retrig_full_hold", 3'b111, 1'b1, 2'b11, 1'b0);
    run(2'b00, 2'b00, 1'b0, 1);
    expect_out("retrig_release", 3'b110, 1'b1, 2'b11, 1'b0);
    run(2'b00, 2'b00, 1'b0, 4);

    // Async reset mid-release, then clear colliding with a new cause.
    run(2'b00, 2'b00, 1'b1, 1);
    run(2'b10, 2'b00, 1'b0, 3);
    run(2'b00, 2'b00, 1'b0, 2);
    expect_out("async_pre_trigger", 3'b111, 1'b1, 2'b10, 1'b0);
    run(2'b00, 2'b00, 1'b0, 5);
    expect_out("async_pre_release", 3'b110, 1'b1, 2'b10, 1'b0);
    apply_async();
    run(2'b10, 2'b00, 1'b0, 3);
    run(2'b00, 2'b00, 1'b0, 1);
    run(2'b00, 2'b00, 1'b1, 1);
    expect_out("clr_vs_set", 3'b111, 1'b1, 2'b10, 1'b0);
    bus.cause_clr = 1'b0;

    // Random traffic: mixed glitches and valid pulses, mask changes, clears, occasional async reset.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) bus.req = bus.req ^ (NS'(1'b1) << $urandom_range(0, NS - 1));
      if ($urandom_range(0, 39) == 0) bus.req_mask = NS'($urandom_range(0, 3));
      bus.cause_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 399) == 0) apply_async();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
